// File: rtl/uart_baud_gen_if.sv
// ---------------------------------------------------------------------------
// uart_baud_gen_if
//
// Purpose : groups the control and tick signals of the UART baud-rate
//           generator into one bundle. The UART TX/RX logic holds the master
//           side; the generator holds the slave side.
//
// Signals :
//   en          master->slave  global block enable (low = freeze everything)
//   enable      master->slave  run request, counter advances while high
//   clear       master->slave  synchronous restart of counter and bit index
//   div         master->slave  requested terminal count (period = div+1)
//   div_load    master->slave  one-cycle strobe capturing div as pending
//   at_max      slave->master  bit tick, one cycle at terminal count
//   at_half     slave->master  mid-bit tick for RX sample centring
//   bit_idx     slave->master  index of the current bit within the frame
//   frame_done  slave->master  bit tick that ends the frame
//   div_pending slave->master  a captured divisor waits for a bit boundary
// ---------------------------------------------------------------------------
interface uart_baud_gen_if #(
    parameter int CNT_W  = 12,
    parameter int BIDX_W = 4
);
    logic              en;
    logic              enable;
    logic              clear;
    logic [CNT_W-1:0]  div;
    logic              div_load;
    logic              at_max;
    logic              at_half;
    logic [BIDX_W-1:0] bit_idx;
    logic              frame_done;
    logic              div_pending;

    modport master (
        output en,
        output enable,
        output clear,
        output div,
        output div_load,
        input  at_max,
        input  at_half,
        input  bit_idx,
        input  frame_done,
        input  div_pending
    );

    modport slave (
        input  en,
        input  enable,
        input  clear,
        input  div,
        input  div_load,
        output at_max,
        output at_half,
        output bit_idx,
        output frame_done,
        output div_pending
    );
endinterface

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
//
// Purpose : runtime-programmable baud-rate generator for the UART TX/RX
//           paths, clocked from the 10 MHz system clock. Produces a one-cycle
//           bit tick every div_active+1 clocks, a mid-bit tick for RX
//           sampling, a per-frame bit index and a frame-complete flag.
//           A newly requested divisor is held in a shadow register and only
//           takes effect at a bit boundary, so the rate never glitches.
//
// Ports   :
//   MHz10  in   system clock, rising edge
//   nrst   in   asynchronous active-low reset
//   bus    slave side of uart_baud_gen_if (controls in, ticks/status out)
//
// Parameters:
//   CNT_W       width of the cycle counter and divisor
//   DEFAULT_DIV divisor loaded at reset (319 -> 31250 baud at 10 MHz)
//   FRAME_BITS  bit ticks per frame (start + 8 data + stop)
//   BIDX_W      width of bit_idx; 2**BIDX_W must be >= FRAME_BITS
// ---------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CNT_W       = 12,
    parameter int DEFAULT_DIV = 319,
    parameter int FRAME_BITS  = 10,
    parameter int BIDX_W      = 4
) (
    input  logic           MHz10,
    input  logic           nrst,
    uart_baud_gen_if.slave bus
);

    localparam logic [CNT_W-1:0]  RESET_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [BIDX_W-1:0] LAST_BIT  = BIDX_W'(FRAME_BITS - 1);

    // A divisor of 0 would give a one-clock period with no distinct mid-bit
    // position; the smallest usable divisor is 1 (two-clock period).
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d == '0) ? CNT_W'(1) : d;
    endfunction

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  div_active;
    logic [CNT_W-1:0]  div_shadow;
    logic              div_pend;
    logic [BIDX_W-1:0] bit_cnt;

    logic              do_clear;
    logic              do_count;
    logic              wrap;
    logic              tick;
    logic              half_tick;
    logic              apply;
    logic [CNT_W-1:0]  div_in;

    assign do_clear  = bus.en & bus.clear;
    assign do_count  = bus.en & ~bus.clear & bus.enable;

    // >= rather than == so a counter left above a freshly shrunk divisor
    // (divisor applied while stopped) still wraps on the next counting cycle.
    assign wrap      = (count >= div_active);
    assign tick      = do_count & wrap;
    assign half_tick = do_count & (count == (div_active >> 1));

    // Bit boundaries at which a pending divisor may be swapped in: the
    // terminal tick, a restart, or any cycle where the counter is stopped.
    assign apply     = bus.en & (tick | bus.clear | ~bus.enable);
    assign div_in    = clamp_div(bus.div);

    // Cycle counter and bit index
    always_ff @(posedge MHz10 or negedge nrst) begin
        if (!nrst) begin
            count   <= '0;
            bit_cnt <= '0;
        end else if (do_clear) begin
            count   <= '0;
            bit_cnt <= '0;
        end else if (do_count) begin
            if (wrap) begin
                count   <= '0;
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIDX_W'(1);
            end else begin
                count   <= count + CNT_W'(1);
            end
        end
    end

    // Divisor shadow / apply
    // Capture ignores en so software can reprogram a gated block; when the
    // strobe lands on a boundary the incoming value bypasses the shadow.
    always_ff @(posedge MHz10 or negedge nrst) begin
        if (!nrst) begin
            div_active <= RESET_DIV;
            div_shadow <= '0;
            div_pend   <= 1'b0;
        end else if (bus.div_load) begin
            div_shadow <= div_in;
            if (apply) begin
                div_active <= div_in;
                div_pend   <= 1'b0;
            end else begin
                div_pend   <= 1'b1;
            end
        end else if (apply && div_pend) begin
            div_active <= div_shadow;
            div_pend   <= 1'b0;
        end
    end

    // Outputs
    assign bus.at_max      = tick;
    assign bus.at_half     = half_tick;
    assign bus.frame_done  = tick & (bit_cnt == LAST_BIT);
    assign bus.bit_idx     = bit_cnt;
    assign bus.div_pending = div_pend;

endmodule

// File: tb/tb_uart_baud_gen.sv
// ---------------------------------------------------------------------------
// tb_uart_baud_gen
//
// Self-checking bench for uart_baud_gen. A behavioural model (bit period
// position, period length, pending divisor, bit number) predicts every
// output each cycle; directed scenarios additionally check absolute tick
// positions derived by hand.
// ---------------------------------------------------------------------------
module tb_uart_baud_gen;

    localparam int CNT_W       = 12;
    localparam int DEFAULT_DIV = 319;
    localparam int FRAME_BITS  = 10;
    localparam int BIDX_W      = 4;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             en = 1'b0;
    logic             enable = 1'b0;
    logic             clear = 1'b0;
    logic             div_load = 1'b0;
    logic [CNT_W-1:0] div = '0;

    uart_baud_gen_if #(.CNT_W(CNT_W), .BIDX_W(BIDX_W)) bus();

    assign bus.en       = en;
    assign bus.enable   = enable;
    assign bus.clear    = clear;
    assign bus.div      = div;
    assign bus.div_load = div_load;

    uart_baud_gen #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV),
        .FRAME_BITS (FRAME_BITS),
        .BIDX_W     (BIDX_W)
    ) dut (
        .MHz10(clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position inside the current bit period, the divisor
    // in force, a waiting divisor, and the bit number in the frame.
    int m_pos, m_div, m_shadow, m_pend, m_bit;

    // Observed / expected {at_max, at_half, frame_done, div_pending, bit_idx}
    logic [7:0] obs, expv;
    logic       e_max;

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic model_reset();
        m_pos    = 0;
        m_div    = DEFAULT_DIV;
        m_shadow = 0;
        m_pend   = 0;
        m_bit    = 0;
    endtask

    // Called just after a rising edge with inputs already driven. Samples
    // DUT outputs on the falling edge, forms the model prediction, then
    // advances the model across the next rising edge.
    task automatic clk_cycle();
        logic run, e_half, e_fd, apply;
        int   cl;
        @(negedge clk);
        obs    = {bus.at_max, bus.at_half, bus.frame_done, bus.div_pending, bus.bit_idx};
        run    = en && !clear && enable;
        e_max  = run && (m_pos >= m_div);
        e_half = run && (m_pos == m_div / 2);
        e_fd   = e_max && (m_bit == FRAME_BITS - 1);
        expv   = {e_max, e_half, e_fd, (m_pend != 0), 4'(m_bit)};
        @(posedge clk);
        if (!nrst) begin
            model_reset();
        end else begin
            apply = en && (e_max || clear || !enable);
            cl    = (div == 0) ? 1 : int'(div);
            if (div_load) begin
                m_shadow = cl;
                if (apply) begin
                    m_div  = cl;
                    m_pend = 0;
                end else begin
                    m_pend = 1;
                end
            end else if (apply && m_pend != 0) begin
                m_div  = m_shadow;
                m_pend = 0;
            end
            if (en) begin
                if (clear) begin
                    m_pos = 0;
                    m_bit = 0;
                end else if (enable) begin
                    if (e_max) begin
                        m_pos = 0;
                        m_bit = (m_bit + 1) % FRAME_BITS;
                    end else begin
                        m_pos++;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        nrst     = 1'b0;
        en       = 1'b1;
        enable   = 1'b0;
        clear    = 1'b0;
        div_load = 1'b0;
        div      = '0;
        model_reset();
        clk_cycle();
        clk_cycle();
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        nrst   = 1'b0;
        en     = 1'b1;
        enable = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            clk_cycle();
            checks++;
            if (obs !== 8'h00) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 00", c, obs);
            end
        end
        nrst = 1'b1;
    endtask

    task automatic test_defaults();
        int ticks[$];
        int halves[$];
        do_reset();
        en     = 1'b1;
        enable = 1'b1;
        for (int c = 0; c < 700; c++) begin
            clk_cycle();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL defaults_model cycle %0d: got %h expected %h", c, obs, expv);
            end
            if (obs[7]) ticks.push_back(c);
            if (obs[6]) halves.push_back(c);
        end
        checks++;
        if (ticks.size() != 2 || qget(ticks, 0) != 319 || qget(ticks, 1) != 639) begin
            errors++;
            $display("FAIL defaults_ticks: got n=%0d first=%0d second=%0d expected n=2 319 639",
                     ticks.size(), qget(ticks, 0), qget(ticks, 1));
        end
        checks++;
        if (halves.size() != 2 || qget(halves, 0) != 159 || qget(halves, 1) != 479) begin
            errors++;
            $display("FAIL defaults_half: got n=%0d first=%0d second=%0d expected n=2 159 479",
                     halves.size(), qget(halves, 0), qget(halves, 1));
        end
    endtask

    task automatic test_frame();
        int ticks[$];
        int fds[$];
        do_reset();
        en       = 1'b1;
        enable   = 1'b0;
        div_load = 1'b1;
        div      = 12'd9;
        clk_cycle();
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL frame_load: got %h expected %h", obs, expv);
        end
        div_load = 1'b0;
        enable   = 1'b1;
        for (int c = 0; c < 100; c++) begin
            clk_cycle();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL frame_model cycle %0d: got %h expected %h", c, obs, expv);
            end
            if (obs[7]) ticks.push_back(c);
            if (obs[5]) fds.push_back(c);
            if (c == 95) begin
                checks++;
                if (obs[3:0] !== 4'd9) begin
                    errors++;
                    $display("FAIL frame_bit_idx: got %0d expected 9", obs[3:0]);
                end
            end
        end
        checks++;
        if (ticks.size() != 10) begin
            errors++;
            $display("FAIL frame_tick_count: got %0d expected 10", ticks.size());
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (qget(ticks, k) != 9 + 10 * k) begin
                errors++;
                $display("FAIL frame_tick_pos k=%0d: got %0d expected %0d", k, qget(ticks, k), 9 + 10 * k);
            end
        end
        checks++;
        if (fds.size() != 1 || qget(fds, 0) != 99) begin
            errors++;
            $display("FAIL frame_done: got n=%0d at %0d expected n=1 at 99", fds.size(), qget(fds, 0));
        end
    endtask

    task automatic test_div_change();
        int ticks[$];
        do_reset();
        en     = 1'b1;
        enable = 1'b1;
        div    = 12'd49;
        for (int c = 0; c < 450; c++) begin
            div_load = (c == 100);
            clk_cycle();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL divchg_model cycle %0d: got %h expected %h", c, obs, expv);
            end
            if (obs[7]) ticks.push_back(c);
            if (c == 101 || c == 319) begin
                checks++;
                if (obs[4] !== 1'b1) begin
                    errors++;
                    $display("FAIL divchg_pending cycle %0d: got %b expected 1", c, obs[4]);
                end
            end
            if (c == 320) begin
                checks++;
                if (obs[4] !== 1'b0) begin
                    errors++;
                    $display("FAIL divchg_applied: got %b expected 0", obs[4]);
                end
            end
        end
        div_load = 1'b0;
        checks++;
        if (ticks.size() != 3 || qget(ticks, 0) != 319 || qget(ticks, 1) != 369 || qget(ticks, 2) != 419) begin
            errors++;
            $display("FAIL divchg_ticks: got n=%0d %0d %0d %0d expected 319 369 419",
                     ticks.size(), qget(ticks, 0), qget(ticks, 1), qget(ticks, 2));
        end
    endtask

    task automatic test_clear();
        int first_after;
        first_after = -1;
        do_reset();
        en     = 1'b1;
        enable = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            clear = (c == 1160);
            clk_cycle();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL clear_model cycle %0d: got %h expected %h", c, obs, expv);
            end
            if (c == 1160) begin
                checks++;
                if (obs[3:0] !== 4'd3 || obs[7] !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_cycle: got bit_idx=%0d at_max=%b expected 3 0", obs[3:0], obs[7]);
                end
            end
            if (c == 1161) begin
                checks++;
                if (obs[3:0] !== 4'd0) begin
                    errors++;
                    $display("FAIL clear_bit_idx: got %0d expected 0", obs[3:0]);
                end
            end
            if (c > 1160 && obs[7] && first_after < 0) first_after = c;
        end
        clear = 1'b0;
        checks++;
        if (first_after != 1480) begin
            errors++;
            $display("FAIL clear_next_tick: got %0d expected 1480", first_after);
        end
    endtask

    task automatic test_gating();
        int gated_ticks;
        int first_after;
        gated_ticks = 0;
        first_after = -1;
        do_reset();
        div = 12'd29;
        for (int c = 0; c < 240; c++) begin
            en       = !(c >= 100 && c < 150);
            enable   = (c != 150);
            div_load = (c == 120);
            clk_cycle();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL gating_model cycle %0d: got %h expected %h", c, obs, expv);
            end
            if (c >= 100 && c < 150 && (obs[7] || obs[6])) gated_ticks++;
            if (c == 121 || c == 150) begin
                checks++;
                if (obs[4] !== 1'b1) begin
                    errors++;
                    $display("FAIL gating_pending cycle %0d: got %b expected 1", c, obs[4]);
                end
            end
            if (c == 151) begin
                checks++;
                if (obs[4] !== 1'b0) begin
                    errors++;
                    $display("FAIL gating_applied: got %b expected 0", obs[4]);
                end
            end
            if (c > 150 && obs[7] && first_after < 0) first_after = c;
        end
        en       = 1'b1;
        enable   = 1'b1;
        div_load = 1'b0;
        checks++;
        if (gated_ticks != 0) begin
            errors++;
            $display("FAIL gating_no_ticks: got %0d expected 0", gated_ticks);
        end
        checks++;
        if (first_after != 151) begin
            errors++;
            $display("FAIL gating_resume: got %0d expected 151", first_after);
        end
    endtask

    task automatic test_zero_clamp();
        do_reset();
        en       = 1'b1;
        enable   = 1'b0;
        div_load = 1'b1;
        div      = 12'd9;
        clk_cycle();
        enable = 1'b1;
        for (int c = 0; c < 21; c++) begin
            div_load = (c == 9);
            div      = '0;
            clk_cycle();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL clamp_model cycle %0d: got %h expected %h", c, obs, expv);
            end
            if (c >= 10) begin
                checks++;
                if (obs[7] !== c[0] || obs[6] !== !c[0] || obs[4] !== 1'b0) begin
                    errors++;
                    $display("FAIL clamp_pattern cycle %0d: got max=%b half=%b pend=%b expected %b %b 0",
                             c, obs[7], obs[6], obs[4], c[0], !c[0]);
                end
            end
        end
        div_load = 1'b0;
    endtask

    task automatic test_async_reset();
        int first_tick;
        first_tick = -1;
        do_reset();
        en       = 1'b1;
        enable   = 1'b0;
        div_load = 1'b1;
        div      = 12'd3;
        clk_cycle();
        enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            div_load = (c == 9);
            div      = 12'd7;
            clk_cycle();
        end
        div_load = 1'b0;
        checks++;
        if (bus.bit_idx !== 4'd2 || bus.div_pending !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got bit_idx=%0d pend=%b expected 2 1", bus.bit_idx, bus.div_pending);
        end
        #2 nrst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.bit_idx !== 4'd0 || bus.div_pending !== 1'b0 || bus.at_max !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got bit_idx=%0d pend=%b max=%b expected 0 0 0",
                     bus.bit_idx, bus.div_pending, bus.at_max);
        end
        @(posedge clk);
        #1 nrst = 1'b1;
        for (int c = 0; c < 330; c++) begin
            clk_cycle();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL async_model cycle %0d: got %h expected %h", c, obs, expv);
            end
            if (obs[7] && first_tick < 0) first_tick = c;
        end
        checks++;
        if (first_tick != 319) begin
            errors++;
            $display("FAIL async_default_div: got %0d expected 319", first_tick);
        end
    endtask

    task automatic test_random();
        int ticks_seen;
        ticks_seen = 0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            en       = ($urandom_range(0, 9) != 0);
            enable   = ($urandom_range(0, 4) != 0);
            clear    = ($urandom_range(0, 39) == 0);
            div_load = ($urandom_range(0, 19) == 0);
            div      = 12'($urandom_range(0, 20));
            clk_cycle();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL random_model cycle %0d: got %h expected %h", c, obs, expv);
            end
            if (obs[7]) ticks_seen++;
        end
        en       = 1'b1;
        enable   = 1'b0;
        clear    = 1'b0;
        div_load = 1'b0;
        checks++;
        if (ticks_seen < 20) begin
            errors++;
            $display("FAIL random_activity: got %0d ticks expected at least 20", ticks_seen);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_defaults();
        test_frame();
        test_div_change();
        test_clear();
        test_gating();
        test_zero_clamp();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
